// File: rtl/obc_dft_pkg.sv
// Shared definitions for the OBC DFT datapath: ROM word geometry, default
// sample width, the shift-accumulator FSM states and a sign-extension helper
// used by the adder tree.
package obc_dft_pkg;

  localparam int ROM_W   = 32;         // sign + 10 integer + 21 fraction bits
  localparam int N_TERMS = 8;          // ROM words summed per bit slice
  localparam int N_BITS  = 16;         // default input sample width
  localparam int SUM_W   = ROM_W + 3;  // growth of an 8-term sum

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FINAL
  } obc_state_e;

  // Sign-extend one ROM word to the adder-tree sum width.
  function automatic logic signed [SUM_W-1:0] sext_rom(input logic [ROM_W-1:0] v);
    return {{(SUM_W-ROM_W){v[ROM_W-1]}}, v};
  endfunction

endpackage

// File: rtl/obc_adder_tree.sv
// Purely combinational three-level balanced adder tree.
// Ports:
//   i_rom : N_TERMS signed ROM_W-bit ROM words for the current bit slice
//   o_sum : signed SUM_W-bit sum (ROM_W+3), cannot overflow
module obc_adder_tree
  import obc_dft_pkg::*;
(
  input  logic        [ROM_W-1:0] i_rom [N_TERMS],
  output logic signed [SUM_W-1:0] o_sum
);

  logic signed [SUM_W-1:0] w_l0 [N_TERMS];
  logic signed [SUM_W-1:0] w_l1 [N_TERMS/2];
  logic signed [SUM_W-1:0] w_l2 [N_TERMS/4];

  // Every level is carried at the full sum width; the extension is done once
  // at the leaves so no intermediate width bookkeeping is needed.
  always_comb begin
    for (int unsigned i = 0; i < N_TERMS; i++) begin
      w_l0[i] = sext_rom(i_rom[i]);
    end
    for (int unsigned i = 0; i < N_TERMS/2; i++) begin
      w_l1[i] = w_l0[2*i] + w_l0[2*i+1];
    end
    for (int unsigned i = 0; i < N_TERMS/4; i++) begin
      w_l2[i] = w_l1[2*i] + w_l1[2*i+1];
    end
    o_sum = w_l2[0] + w_l2[1];
  end

endmodule

// File: rtl/obc_shift_accumulator.sv
// Bit-serial OBC shift-accumulate stage. Each ACCUM cycle requests one bit
// slice (bit_sel, MSB first), sums the eight ROM words for that slice and
// accumulates; the sign-bit slice is negated. The OBC offset is added in
// FINAL and the result is presented on y_out with a one-cycle y_valid pulse.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : begin a transaction (accepted only in IDLE)
//   offset_in       : signed OBC offset, sampled on the accepted start
//   rom0..rom7      : signed ROM words for the slice selected by bit_sel
//   bit_sel         : slice index requested from the serializer
//   busy            : transaction in flight
//   y_out, y_valid  : signed result and its one-cycle update strobe
module obc_shift_accumulator #(
  parameter int N_BITS = obc_dft_pkg::N_BITS,
  parameter int ROM_W  = obc_dft_pkg::ROM_W,
  parameter int ACC_W  = ROM_W + 3 + N_BITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic        [ROM_W-1:0]   offset_in,
  input  logic        [ROM_W-1:0]   rom0,
  input  logic        [ROM_W-1:0]   rom1,
  input  logic        [ROM_W-1:0]   rom2,
  input  logic        [ROM_W-1:0]   rom3,
  input  logic        [ROM_W-1:0]   rom4,
  input  logic        [ROM_W-1:0]   rom5,
  input  logic        [ROM_W-1:0]   rom6,
  input  logic        [ROM_W-1:0]   rom7,
  output logic [$clog2(N_BITS)-1:0] bit_sel,
  output logic                      busy,
  output logic signed [ACC_W-1:0]   y_out,
  output logic                      y_valid
);

  import obc_dft_pkg::*;

  localparam int                CNT_W   = $clog2(N_BITS);
  localparam logic [CNT_W-1:0]  CNT_TOP = CNT_W'(N_BITS - 1);

  obc_state_e              r_state;
  obc_state_e              w_state_nxt;
  logic        [CNT_W-1:0] r_cnt;
  logic        [ROM_W-1:0] r_offset;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_y;
  logic                    r_y_valid;

  logic        [ROM_W-1:0] w_rom [N_TERMS];
  logic signed [SUM_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_sum_ext;
  logic signed [ACC_W-1:0] w_off_ext;

  assign w_rom[0] = rom0;
  assign w_rom[1] = rom1;
  assign w_rom[2] = rom2;
  assign w_rom[3] = rom3;
  assign w_rom[4] = rom4;
  assign w_rom[5] = rom5;
  assign w_rom[6] = rom6;
  assign w_rom[7] = rom7;

  obc_adder_tree u_adder_tree (
    .i_rom (w_rom),
    .o_sum (w_sum)
  );

  assign w_sum_ext = {{(ACC_W-SUM_W){w_sum[SUM_W-1]}}, w_sum};
  assign w_off_ext = {{(ACC_W-ROM_W){r_offset[ROM_W-1]}}, r_offset};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = ACCUM;
      ACCUM:   if (r_cnt == '0) w_state_nxt = FINAL;
      FINAL:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    bit_sel = CNT_TOP;
    busy    = 1'b0;
    if (r_state == ACCUM) begin
      bit_sel = r_cnt;
    end
    if (r_state != IDLE) begin
      busy = 1'b1;
    end
  end

  // Datapath: the MSB slice carries weight -2^(N_BITS-1), so it seeds the
  // accumulator negated; every later slice shifts the running value up.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_offset  <= '0;
      r_acc     <= '0;
      r_y       <= '0;
      r_y_valid <= 1'b0;
    end else begin
      r_y_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_offset <= offset_in;
            r_cnt    <= CNT_TOP;
          end
        end
        ACCUM: begin
          if (r_cnt == CNT_TOP) begin
            r_acc <= -w_sum_ext;
          end else begin
            r_acc <= (r_acc <<< 1) + w_sum_ext;
          end
          r_cnt <= r_cnt - 1'b1;
        end
        FINAL: begin
          r_y       <= r_acc + w_off_ext;
          r_y_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign y_out   = r_y;
  assign y_valid = r_y_valid;

endmodule

// File: tb/tb_obc_shift_accumulator.sv
module tb_obc_shift_accumulator;

  localparam int NB = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic        [31:0] offset_in = '0;
  logic        [31:0] rom0, rom1, rom2, rom3, rom4, rom5, rom6, rom7;
  logic        [3:0]  bit_sel;
  logic               busy;
  logic signed [50:0] y_out;
  logic               y_valid;

  int checks = 0;
  int failures = 0;

  // Upstream ROM model: one row of eight words per bit slice.
  logic [31:0] tab [NB][8];
  int          bs_hist [64];
  int          busy_cnt;

  always #5 clk = ~clk;

  always_comb begin
    rom0 = tab[bit_sel][0];
    rom1 = tab[bit_sel][1];
    rom2 = tab[bit_sel][2];
    rom3 = tab[bit_sel][3];
    rom4 = tab[bit_sel][4];
    rom5 = tab[bit_sel][5];
    rom6 = tab[bit_sel][6];
    rom7 = tab[bit_sel][7];
  end

  obc_shift_accumulator #(.N_BITS(16), .ROM_W(32), .ACC_W(51)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .offset_in (offset_in),
    .rom0      (rom0),
    .rom1      (rom1),
    .rom2      (rom2),
    .rom3      (rom3),
    .rom4      (rom4),
    .rom5      (rom5),
    .rom6      (rom6),
    .rom7      (rom7),
    .bit_sel   (bit_sel),
    .busy      (busy),
    .y_out     (y_out),
    .y_valid   (y_valid)
  );

  // Reference: y = offset - S[15]*2^15 + sum_{k<15} S[k]*2^k
  function automatic longint ref_y(input logic [31:0] off);
    longint acc = 0;
    for (int k = 0; k < NB; k++) begin
      longint s = 0;
      longint w = longint'(1) << k;
      for (int j = 0; j < 8; j++) s += longint'(signed'(tab[k][j]));
      if (k == NB - 1) acc -= s * w;
      else             acc += s * w;
    end
    return acc + longint'(signed'(off));
  endfunction

  task automatic fill_const(input logic [31:0] v0, input logic [31:0] vrest);
    for (int k = 0; k < NB; k++) begin
      tab[k][0] = v0;
      for (int j = 1; j < 8; j++) tab[k][j] = vrest;
    end
  endtask

  task automatic fill_random();
    for (int k = 0; k < NB; k++)
      for (int j = 0; j < 8; j++) tab[k][j] = $urandom;
  endtask

  // One start pulse; lat = edges from the start-sampling edge to y_valid, -1 on timeout.
  task automatic run_txn(input logic [31:0] off, output longint y, output int lat);
    @(negedge clk);
    start = 1'b1;
    offset_in = off;
    @(posedge clk); #1;
    start = 1'b0;
    bs_hist[0] = int'(bit_sel);
    busy_cnt = busy ? 1 : 0;
    lat = -1;
    y = 0;
    for (int m = 1; m <= 40; m++) begin
      @(posedge clk); #1;
      bs_hist[m] = int'(bit_sel);
      if (busy) busy_cnt++;
      if (y_valid) begin
        lat = m;
        y = longint'(y_out);
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", y_valid); end
    checks++; if (y_out !== 51'sd0) begin failures++; $display("FAIL reset_y got=%0d exp=0", y_out); end
    checks++; if (bit_sel !== 4'd15) begin failures++; $display("FAIL reset_bitsel got=%0d exp=15", bit_sel); end
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_unit();
    longint y;
    int lat;
    int bad;
    fill_const(32'd1, 32'd0);
    run_txn(32'd0, y, lat);
    checks++; if (lat != NB + 1) begin failures++; $display("FAIL unit_latency got=%0d exp=%0d", lat, NB + 1); end
    checks++; if (y != -1) begin failures++; $display("FAIL unit_value got=%0d exp=-1", y); end
    bad = 0;
    for (int i = 0; i < NB; i++) if (bs_hist[i] != NB - 1 - i) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL unit_bitsel_seq got=%0d_wrong_entries exp=0", bad); end
    checks++; if (busy_cnt != NB + 1) begin failures++; $display("FAIL unit_busy_cycles got=%0d exp=%0d", busy_cnt, NB + 1); end
    checks++; if (bs_hist[NB + 1] != NB - 1) begin failures++; $display("FAIL unit_bitsel_idle got=%0d exp=15", bs_hist[NB + 1]); end
    @(posedge clk); #1;
    checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL unit_valid_pulse got=%0b exp=0", y_valid); end
    checks++; if (longint'(y_out) != -1) begin failures++; $display("FAIL unit_hold got=%0d exp=-1", y_out); end
  endtask

  task automatic test_offset();
    longint y;
    int lat;
    fill_const(32'd0, 32'd0);
    run_txn(32'h0000_0100, y, lat);
    checks++; if (lat != NB + 1 || y != 256) begin failures++; $display("FAIL offset_pos got=%0d lat=%0d exp=256", y, lat); end
    run_txn(32'hFFFF_FF00, y, lat);
    checks++; if (lat != NB + 1 || y != -256) begin failures++; $display("FAIL offset_neg got=%0d lat=%0d exp=-256", y, lat); end
  endtask

  task automatic test_bit_dependent();
    longint y;
    int lat;
    fill_const(32'd0, 32'd0);
    for (int k = 0; k < NB; k += 2) tab[k][0] = 32'd3;
    run_txn(32'd0, y, lat);
    checks++; if (lat != NB + 1 || y != 65535) begin failures++; $display("FAIL bitdep got=%0d lat=%0d exp=65535", y, lat); end
  endtask

  task automatic test_extreme();
    longint y;
    int lat;
    fill_const(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    run_txn(32'd0, y, lat);
    checks++; if (lat != NB + 1 || y != -64'sd17179869176) begin failures++; $display("FAIL extreme_max got=%0d lat=%0d exp=-17179869176", y, lat); end
    fill_const(32'h8000_0000, 32'h8000_0000);
    run_txn(32'd0, y, lat);
    checks++; if (lat != NB + 1 || y != 64'sd17179869184) begin failures++; $display("FAIL extreme_min got=%0d lat=%0d exp=17179869184", y, lat); end
  endtask

  task automatic test_random();
    longint y;
    longint e;
    int lat;
    logic [31:0] off;
    for (int t = 0; t < 20; t++) begin
      fill_random();
      off = $urandom;
      e = ref_y(off);
      run_txn(off, y, lat);
      checks++;
      if (lat != NB + 1 || y != e) begin
        failures++;
        $display("FAIL random_%0d got=%0d lat=%0d exp=%0d", t, y, lat, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    longint e;
    logic [31:0] off;
    int hits [3];
    longint ys [3];
    int n;
    fill_random();
    off = $urandom;
    e = ref_y(off);
    n = 0;
    @(negedge clk);
    start = 1'b1;
    offset_in = off;
    for (int m = 0; m <= 70 && n < 3; m++) begin
      @(posedge clk); #1;
      if (y_valid) begin
        hits[n] = m;
        ys[n] = longint'(y_out);
        n++;
      end
    end
    start = 1'b0;
    checks++; if (n != 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", n); end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (hits[i] != 17 + 18 * i || ys[i] != e) begin
        failures++;
        $display("FAIL b2b_result_%0d got=%0d at_edge=%0d exp=%0d at_edge=%0d", i, ys[i], hits[i], e, 17 + 18 * i);
      end
    end
    repeat (25) @(posedge clk);
  endtask

  task automatic test_start_while_busy();
    longint e;
    longint y;
    logic [31:0] off;
    int lat;
    int extra;
    fill_random();
    off = $urandom;
    e = ref_y(off);
    lat = -1;
    y = 0;
    extra = 0;
    @(negedge clk);
    start = 1'b1;
    offset_in = off;
    @(posedge clk); #1;
    start = 1'b0;
    for (int m = 1; m <= 40; m++) begin
      @(posedge clk); #1;
      if (m == 5) begin
        start = 1'b1;
        offset_in = ~off;
      end else begin
        start = 1'b0;
      end
      if (y_valid) begin
        lat = m;
        y = longint'(y_out);
        break;
      end
    end
    checks++; if (lat != NB + 1 || y != e) begin failures++; $display("FAIL busy_start got=%0d lat=%0d exp=%0d", y, lat, e); end
    for (int m = 0; m < 25; m++) begin
      @(posedge clk); #1;
      if (y_valid || busy) extra++;
    end
    checks++; if (extra != 0) begin failures++; $display("FAIL busy_start_not_queued got=%0d exp=0", extra); end
  endtask

  task automatic test_reset_mid();
    longint e;
    longint y;
    int lat;
    int stray;
    logic was_busy;
    fill_random();
    @(negedge clk);
    start = 1'b1;
    offset_in = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    was_busy = busy;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (was_busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before got=%0b exp=1", was_busy); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%0b exp=0", busy); end
    checks++; if (y_out !== 51'sd0) begin failures++; $display("FAIL rstmid_y got=%0d exp=0", y_out); end
    checks++; if (bit_sel !== 4'd15) begin failures++; $display("FAIL rstmid_bitsel got=%0d exp=15", bit_sel); end
    stray = 0;
    for (int m = 0; m < 25; m++) begin
      @(posedge clk); #1;
      if (y_valid) stray++;
    end
    checks++; if (stray != 0) begin failures++; $display("FAIL rstmid_no_valid got=%0d exp=0", stray); end
    fill_random();
    offset_in = $urandom;
    e = ref_y(offset_in);
    run_txn(offset_in, y, lat);
    checks++; if (lat != NB + 1 || y != e) begin failures++; $display("FAIL rstmid_after got=%0d lat=%0d exp=%0d", y, lat, e); end
  endtask

  initial begin
    fill_const(32'd0, 32'd0);
    test_reset();
    test_unit();
    test_offset();
    test_bit_dependent();
    test_extreme();
    test_random();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
